// File: rtl/scpu_pipe_pkg.sv
// Shared types and constants for the scpu pipeline hazard controller.
package scpu_pipe_pkg;

   typedef enum logic [1:0] {
      StRun,
      StMwait,
      StBubble
   } pipe_state_e;

   localparam logic [31:0] NOP_INST       = 32'h00000013;
   localparam int unsigned REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard inputs from the pipe, stage enables/flushes back to it.
// slave is the controller's view; master is the pipeline's view.
interface pipe_hazard_ctrl_if
   import scpu_pipe_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
);
   logic                  mem_valid;
   logic                  mmu_data_ready;
   logic                  ex_redirect;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic                  pc_write;
   logic                  ifid_write;
   logic                  ifid_flush;
   logic                  idex_write;
   logic                  idex_flush;
   logic                  exmem_write;
   logic                  memwb_write;
   logic                  mem_timeout;
   logic [31:0]           stall_cycles;
   logic [31:0]           bubble_cycles;

   modport master (
      output mem_valid, mmu_data_ready, ex_redirect, ex_mem_read, ex_rd,
             id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, memwb_write, mem_timeout, stall_cycles, bubble_cycles
   );

   modport slave (
      input  mem_valid, mmu_data_ready, ex_redirect, ex_mem_read, ex_rd,
             id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, memwb_write, mem_timeout, stall_cycles, bubble_cycles
   );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the EX load and ID sources.
module load_use_detect #(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   output logic                  load_use_o
);

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) &&
                       ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                        (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer and memory-wait watchdog for the 5-stage scpu pipeline.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import scpu_pipe_pkg::*;
#(
   parameter int unsigned REG_ADDR_W       = REG_ADDR_W_DEF,
   parameter int unsigned REDIRECT_BUBBLES = 1,
   parameter int unsigned MEM_TIMEOUT      = 256
) (
   input logic             clk,
   input logic             rst,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int unsigned      WaitW     = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WaitW-1:0] WaitMax   = '1;
   localparam logic [WaitW-1:0] TimeoutAt = WaitW'(MEM_TIMEOUT - 1);
   localparam logic [3:0]       BubInit   =
      (REDIRECT_BUBBLES > 0) ? 4'(REDIRECT_BUBBLES - 1) : 4'd0;

   pipe_state_e      state_q, state_d;
   logic [3:0]       bub_cnt_q, bub_cnt_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic             mem_stall, load_use;
   logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
   logic             exmem_write, memwb_write;

   assign mem_stall = bus.mem_valid && !bus.mmu_data_ready;

   load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detect (
      .ex_mem_read_i (bus.ex_mem_read),
      .ex_rd_i       (bus.ex_rd),
      .id_rs1_i      (bus.id_rs1),
      .id_rs2_i      (bus.id_rs2),
      .id_rs1_used_i (bus.id_rs1_used),
      .id_rs2_used_i (bus.id_rs2_used),
      .load_use_o    (load_use)
   );

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      if (rst || mem_stall) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         memwb_write = 1'b0;
      end else if (bus.ex_redirect) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (state_q == StBubble) begin
         ifid_flush = 1'b1;
      end else if (load_use) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // A stall during BUBBLE stays in BUBBLE with the count frozen, so it resumes afterwards.
   always_comb begin
      state_d   = state_q;
      bub_cnt_d = bub_cnt_q;
      unique case (state_q)
         StRun, StMwait: begin
            if (mem_stall) begin
               state_d = StMwait;
            end else if (bus.ex_redirect && (REDIRECT_BUBBLES > 0)) begin
               state_d   = StBubble;
               bub_cnt_d = BubInit;
            end else begin
               state_d = StRun;
            end
         end
         StBubble: begin
            if (!mem_stall) begin
               if (bus.ex_redirect) begin
                  bub_cnt_d = BubInit;
               end else if (bub_cnt_q == 4'd0) begin
                  state_d = StRun;
               end else begin
                  bub_cnt_d = bub_cnt_q - 4'd1;
               end
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      wait_cnt_d    = '0;
      mem_timeout_d = mem_timeout_q;
      if (mem_stall) begin
         wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
         if (wait_cnt_q == TimeoutAt) begin
            mem_timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         bub_cnt_q     <= 4'd0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bub_cnt_q     <= bub_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles_q, bubble_cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q  <= 32'd0;
         bubble_cycles_q <= 32'd0;
      end else begin
         if (mem_stall || load_use) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (ifid_flush || idex_flush) begin
            bubble_cycles_q <= bubble_cycles_q + 32'd1;
         end
      end
   end

   assign bus.stall_cycles  = stall_cycles_q;
   assign bus.bubble_cycles = bubble_cycles_q;
`else
   assign bus.stall_cycles  = 32'd0;
   assign bus.bubble_cycles = 32'd0;
`endif

   assign bus.pc_write    = pc_write;
   assign bus.ifid_write  = ifid_write;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_write  = idex_write;
   assign bus.idex_flush  = idex_flush;
   assign bus.exmem_write = exmem_write;
   assign bus.memwb_write = memwb_write;
   assign bus.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=2, MEM_TIMEOUT=8).
module tb_pipe_hazard_ctrl;

   // Control vector order: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w}
   localparam logic [6:0] CNorm   = 7'b1101011;
   localparam logic [6:0] CFreeze = 7'b0000000;
   localparam logic [6:0] CRedir  = 7'b1111111;
   localparam logic [6:0] CBub    = 7'b1111011;
   localparam logic [6:0] CLu     = 7'b0001111;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [6:0] ctl;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

   pipe_hazard_ctrl #(
      .REG_ADDR_W       (5),
      .REDIRECT_BUBBLES (2),
      .MEM_TIMEOUT      (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
                 bus.idex_flush, bus.exmem_write, bus.memwb_write};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.mem_valid      = 1'b0;
      bus.mmu_data_ready = 1'b0;
      bus.ex_redirect    = 1'b0;
      bus.ex_mem_read    = 1'b0;
      bus.ex_rd          = 5'd0;
      bus.id_rs1         = 5'd0;
      bus.id_rs2         = 5'd0;
      bus.id_rs1_used    = 1'b0;
      bus.id_rs2_used    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stall(input logic on);
      bus.mem_valid      = on;
      bus.mmu_data_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      #3;
      chk("reset_ctl", 32'(ctl), 32'(CFreeze));
      chk("reset_timeout", 32'(bus.mem_timeout), 32'd0);
      tick();
      rst = 1'b0;
      #3;
      chk("post_reset_norm", 32'(ctl), 32'(CNorm));

      // Load-use through rs1
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
      #3;
      chk("lu_rs1", 32'(ctl), 32'(CLu));
      tick();
      bus.ex_mem_read = 1'b0;
      #3;
      chk("lu_release", 32'(ctl), 32'(CNorm));
      tick();

      // x0 destination and unused rs2 never stall
      idle();
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1;
      #3;
      chk("lu_x0", 32'(ctl), 32'(CNorm));
      tick();
      idle();
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs2 = 5'd9; bus.id_rs1 = 5'd3;
      bus.id_rs1_used = 1'b1;
      #3;
      chk("lu_rs2_unused", 32'(ctl), 32'(CNorm));
      bus.id_rs2_used = 1'b1;
      #1;
      chk("lu_rs2_used", 32'(ctl), 32'(CLu));
      tick();

      // Redirect with two trailing bubbles
      idle();
      bus.ex_redirect = 1'b1;
      #3;
      chk("redir_c0", 32'(ctl), 32'(CRedir));
      tick();
      idle();
      #3;
      chk("redir_c1", 32'(ctl), 32'(CBub));
      tick();
      #3;
      chk("redir_c2", 32'(ctl), 32'(CBub));
      tick();
      #3;
      chk("redir_done", 32'(ctl), 32'(CNorm));
      tick();

      // Stall inside BUBBLE with bub_cnt=1 freezes the count
      bus.ex_redirect = 1'b1;
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         stall(1'b1);
         #3;
         chk($sformatf("bub_freeze_%0d", i), 32'(ctl), 32'(CFreeze));
         tick();
      end
      idle();
      #3;
      chk("bub_resume_1", 32'(ctl), 32'(CBub));
      tick();
      // Bubble outranks load-use
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_rs1_used = 1'b1;
      #3;
      chk("bub_resume_2", 32'(ctl), 32'(CBub));
      tick();
      #3;
      chk("bub_over_lu", 32'(ctl), 32'(CLu));
      tick();
      idle();

      // wait_cnt clears on a non-stall cycle: 5 + 1 gap + 5 never trips
      for (int i = 0; i < 11; i++) begin
         stall(i != 5);
         tick();
      end
      idle();
      #3;
      chk("wait_clear_no_to", 32'(bus.mem_timeout), 32'd0);
      tick();

      // Watchdog: 10-cycle stall with MEM_TIMEOUT=8
      for (int i = 1; i <= 10; i++) begin
         stall(1'b1);
         #3;
         chk($sformatf("to_freeze_%0d", i), 32'(ctl), 32'(CFreeze));
         chk($sformatf("to_flag_%0d", i), 32'(bus.mem_timeout), 32'(i >= 9));
         tick();
      end
      idle();
      #3;
      chk("to_release_ctl", 32'(ctl), 32'(CNorm));
      chk("to_sticky_0", 32'(bus.mem_timeout), 32'd1);
      tick();
      tick();
      #3;
      chk("to_sticky_1", 32'(bus.mem_timeout), 32'd1);

      // Reset during MWAIT with wait_cnt=5
      for (int i = 0; i < 5; i++) begin
         stall(1'b1);
         tick();
      end
      rst = 1'b1;
      #3;
      chk("rst_mwait_ctl", 32'(ctl), 32'(CFreeze));
      tick();
      rst = 1'b0;
      idle();
      #3;
      chk("rst_run_ctl", 32'(ctl), 32'(CNorm));
      chk("rst_to_clear", 32'(bus.mem_timeout), 32'd0);
`ifdef PIPE_PERF_CNT_EN
      chk("rst_stall_cnt", bus.stall_cycles, 32'd0);
      chk("rst_bubble_cnt", bus.bubble_cycles, 32'd0);
`else
      chk("perf_tied_stall", bus.stall_cycles, 32'd0);
`endif
      tick();
      // wait_cnt was cleared: the flag must take a full 8 stall cycles again
      for (int i = 1; i <= 9; i++) begin
         stall(1'b1);
         #3;
         chk($sformatf("rst_wait_%0d", i), 32'(bus.mem_timeout), 32'(i >= 9));
`ifdef PIPE_PERF_CNT_EN
         if (i == 9) chk("perf_stall_8", bus.stall_cycles, 32'd8);
`endif
         tick();
      end
      idle();
      tick();

      // Reset mid-bubble aborts the bubble
      bus.ex_redirect = 1'b1;
      #3;
      chk("rb_redir", 32'(ctl), 32'(CRedir));
      tick();
      idle();
      rst = 1'b1;
      #3;
      chk("rb_rst_ctl", 32'(ctl), 32'(CFreeze));
      tick();
      rst = 1'b0;
      #3;
      chk("rb_run_ctl", 32'(ctl), 32'(CNorm));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage scpu pipeline. It drives the write enables and flush controls of pc, IF/ID, ID/EX, EX/MEM and MEM/WB. It arbitrates between four sources: memory-wait freeze, EX-stage redirect (branch/jump/trap), post-redirect fetch bubbles, and load-use hazards. It also runs a memory-wait watchdog.

Parameters:
REG_ADDR_W, 5, register index width
REDIRECT_BUBBLES, 1, extra cycles IF/ID is flushed after a redirect (0..15)
MEM_TIMEOUT, 256, consecutive memory-wait cycles before mem_timeout is raised (>=2)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
mem_valid  in  1  MEM stage has an outstanding data access
mmu_data_ready  in  1  data access completes this cycle
ex_redirect  in  1  EX resolved a taken branch/jump/trap this cycle
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_ADDR_W  destination register of EX instruction
id_rs1  in  REG_ADDR_W  ID source 1
id_rs2  in  REG_ADDR_W  ID source 2
id_rs1_used  in  1  ID reads rs1
id_rs2_used  in  1  ID reads rs2
pc_write  out  1  pc register load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP (32'h00000013, pc 0)
idex_write  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads bubble
exmem_write  out  1  EX/MEM load enable
memwb_write  out  1  MEM/WB load enable
mem_timeout  out  1  sticky watchdog flag
stall_cycles  out  32  perf counter (optional feature)
bubble_cycles  out  32  perf counter (optional feature)

Behaviour:
- Clock clk, synchronous active-high reset rst. All state changes on posedge clk; outputs are combinational from state plus inputs.
- State machine states: RUN, MWAIT, BUBBLE. Registers: bub_cnt (4b), wait_cnt (log2(MEM_TIMEOUT)+1 b), mem_timeout.
- mem_stall = mem_valid & ~mmu_data_ready.
- load_use = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Output priority per cycle, highest first:
  1. mem_stall: all five write enables 0, no flushes. Whole pipe frozen.
  2. ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_write=1, memwb_write=1.
  3. state==BUBBLE: pc_write=1, ifid_flush=1, all other enables 1, idex_flush=0.
  4. load_use: pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1, memwb_write=1.
  5. Otherwise all enables 1, flushes 0.
- Flush implies write: when a flush is 1, the matching write is also 1.
- Transitions:
  - RUN -> MWAIT on mem_stall.
  - RUN -> BUBBLE on ex_redirect with REDIRECT_BUBBLES>0; bub_cnt <= REDIRECT_BUBBLES-1.
  - BUBBLE: if bub_cnt==0 -> RUN, else bub_cnt decrements. Count is frozen while mem_stall.
  - BUBBLE + ex_redirect: count restarts at REDIRECT_BUBBLES-1.
  - MWAIT -> RUN when mem_stall drops. If ex_redirect in that same cycle, go to BUBBLE per the RUN rule. BUBBLE entered from a stall resumes its saved count.
- wait_cnt: increments every mem_stall cycle and saturates. It clears on any non-stall cycle. When wait_cnt reaches MEM_TIMEOUT-1 while still stalled, mem_timeout <= 1. mem_timeout is cleared only by rst. The stall continues after timeout.
- Reset: state RUN, bub_cnt 0, wait_cnt 0, mem_timeout 0, counters 0. While rst=1 all write enables 0 and flushes 0. Reset mid-stall or mid-bubble aborts the stall or bubble immediately.
- Latency: hazard outputs are same-cycle combinational; state effects begin the next cycle.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each mem_stall or load_use cycle.
  - bubble_cycles increments on each cycle where ifid_flush or idex_flush is 1.
  - Both are 32-bit, wrap, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package scpu_pipe_pkg:
  - state enum (RUN/MWAIT/BUBBLE)
  - NOP_INST = 32'h00000013
  - default REG_ADDR_W
- Sub-module load_use_detect: purely combinational comparator producing load_use.

Test Plan:
1. ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> that cycle pc_write=0, ifid_write=0, idex_flush=1. Next cycle (ex_mem_read=0) all enables 1.
2. Load-use with ex_rd=0 -> no stall. Load-use with id_rs2 matching but id_rs2_used=0 -> no stall.
3. REDIRECT_BUBBLES=2, ex_redirect one cycle -> ifid_flush=1 for 3 consecutive cycles, idex_flush=1 only in the first, pc_write=1 throughout.
4. mem_valid=1, mmu_data_ready=0 for 4 cycles while in BUBBLE with bub_cnt=1 -> all enables 0 for 4 cycles. After ready, 2 more ifid_flush cycles.
5. MEM_TIMEOUT=8, stall held 10 cycles -> mem_timeout rises after the 8th stall cycle and stays 1 after the stall ends until rst.
6. Assert rst in MWAIT with wait_cnt=5 -> next cycle state RUN, wait_cnt 0, mem_timeout 0. With PIPE_PERF_CNT_EN, stall_cycles is 0.
